merlin_timer_target: RTL

//  Memory-mapped machine-timer responder on the merlin data-port request/response protocol (core = initiator, this block = target).

---
 rtl/merlin_timer_target.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/merlin_timer_target.sv
// merlin_timer_target
//   Memory-mapped machine timer that answers the merlin data-port request/response
//   protocol. It holds a 64-bit mtime counter, a 64-bit mtimecmp compare value, a
//   prescaler and a control register. It drives a level timer interrupt.
//   Each accepted request gets exactly one response, returned in order from a
//   2-entry response buffer.
//
//   Register window (byte offset from C_BASE_ADDR; addr[1:0] are ignored):
//     0x00 mtime[31:0]      RW    0x04 mtime[63:32]     RW
//     0x08 mtimecmp[31:0]   RW    0x0C mtimecmp[63:32]  RW
//     0x10 ctrl {irqen,en}  RW    0x14 prescale         RW
//     0x18 status {cmp_hit} RO    0x1C / outside window -> error response
//
// Ports
//   clk_i, resetb_i          clock, asynchronous active-low reset
//   clk_en_i                 global enable; when low every piece of state holds
//   treq*                    request channel (valid/ready, dvalid=1 means write)
//   trsp*                    response channel (valid/ready, rerr/werr, data)
//   timer_irq_o              registered interrupt: irqen & (mtime >= mtimecmp)
module merlin_timer_target #(
    parameter logic [31:0] C_BASE_ADDR  = 32'h0200_0000,
    parameter int          C_PRESCALE_W = 16
) (
    input  logic        clk_i,
    input  logic        resetb_i,
    input  logic        clk_en_i,
    output logic        treqready_o,
    input  logic        treqvalid_i,
    input  logic        treqdvalid_i,
    input  logic [31:0] treqaddr_i,
    input  logic [31:0] treqdata_i,
    input  logic        trspready_i,
    output logic        trspvalid_o,
    output logic        trsprerr_o,
    output logic        trspwerr_o,
    output logic [31:0] trspdata_o,
    output logic        timer_irq_o
);

    typedef struct packed {
        logic [31:0] data;
        logic        rerr;
        logic        werr;
    } rsp_t;

    localparam logic [C_PRESCALE_W-1:0] PCNT_ONE = {{(C_PRESCALE_W-1){1'b0}}, 1'b1};

    // Response buffer: entry 0 is always the head, so a pop shifts entry 1 down.
    rsp_t [1:0]              rsp_q, rsp_d;
    logic [1:0]              rcnt_q, rcnt_d;

    logic [63:0]             mtime_q, mtime_d;
    logic [63:0]             mtimecmp_q, mtimecmp_d;
    logic [1:0]              ctrl_q, ctrl_d;        // [1]=irqen, [0]=en
    logic [C_PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [C_PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                    irq_q, irq_d;

    logic        push, pop, wr_en, in_win, rd_ok, wr_ok, cmp_hit, tick, push_idx;
    logic [2:0]  widx;
    logic [31:0] rd_data;
    rsp_t        new_rsp;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^treqaddr_i[1:0];

    assign trspvalid_o = (rcnt_q != 2'd0);
    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign treqready_o = (rcnt_q < 2'd2) | ((rcnt_q == 2'd2) & trspvalid_o & trspready_i);
    assign trspdata_o  = rsp_q[0].data;
    assign trsprerr_o  = rsp_q[0].rerr;
    assign trspwerr_o  = rsp_q[0].werr;
    assign timer_irq_o = irq_q;

    assign push    = clk_en_i & treqvalid_i & treqready_o;
    assign pop     = clk_en_i & trspvalid_o & trspready_i;
    assign in_win  = (treqaddr_i[31:5] == C_BASE_ADDR[31:5]);
    assign widx    = treqaddr_i[4:2];
    assign cmp_hit = (mtime_q >= mtimecmp_q);
    assign tick    = ctrl_q[0] & (pcnt_q == prescale_q);
    assign rd_ok   = in_win & (widx != 3'd7);
    assign wr_ok   = in_win & (widx < 3'd6);
    assign wr_en   = push & treqdvalid_i & wr_ok;

    // Read data reflects register values before any same-cycle update.
    always_comb begin
        rd_data = 32'd0;
        case (widx)
            3'd0:    rd_data = mtime_q[31:0];
            3'd1:    rd_data = mtime_q[63:32];
            3'd2:    rd_data = mtimecmp_q[31:0];
            3'd3:    rd_data = mtimecmp_q[63:32];
            3'd4:    rd_data = {30'd0, ctrl_q};
            3'd5:    rd_data = 32'(prescale_q);
            3'd6:    rd_data = {31'd0, cmp_hit};
            default: rd_data = 32'd0;
        endcase
    end

    always_comb begin
        new_rsp.data = (!treqdvalid_i && rd_ok) ? rd_data : 32'd0;
        new_rsp.rerr = !treqdvalid_i && !rd_ok;
        new_rsp.werr = treqdvalid_i && !wr_ok;
    end

    // Response buffer bookkeeping.
    always_comb begin
        rsp_d    = rsp_q;
        rcnt_d   = rcnt_q;
        // Slot for the new entry once any same-cycle pop has shifted the buffer.
        push_idx = pop ? ~rcnt_q[0] : rcnt_q[0];
        if (pop) begin
            rsp_d[0] = rsp_q[1];
        end
        if (push) begin
            rsp_d[push_idx] = new_rsp;
        end
        rcnt_d = rcnt_q + {1'b0, push} - {1'b0, pop};
    end

    // Timer and register writes. A write to one mtime half replaces that half
    // only; the other half keeps its pre-increment value (no carry across).
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        irq_d      = irq_q;
        if (clk_en_i) begin
            irq_d = ctrl_q[1] & cmp_hit;
            if (ctrl_q[0]) begin
                if (tick) begin
                    pcnt_d  = '0;
                    mtime_d = mtime_q + 64'd1;
                end else begin
                    pcnt_d  = pcnt_q + PCNT_ONE;
                end
            end
            if (wr_en) begin
                case (widx)
                    3'd0: begin
                        mtime_d = {mtime_q[63:32], treqdata_i};
                        pcnt_d  = '0;
                    end
                    3'd1: begin
                        mtime_d = {treqdata_i, mtime_q[31:0]};
                        pcnt_d  = '0;
                    end
                    3'd2: mtimecmp_d = {mtimecmp_q[63:32], treqdata_i};
                    3'd3: mtimecmp_d = {treqdata_i, mtimecmp_q[31:0]};
                    3'd4: begin
                        ctrl_d = treqdata_i[1:0];
                        pcnt_d = '0;
                    end
                    3'd5: begin
                        prescale_d = treqdata_i[C_PRESCALE_W-1:0];
                        pcnt_d     = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            rsp_q      <= '0;
            rcnt_q     <= 2'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
            ctrl_q     <= 2'd0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            rsp_q      <= rsp_d;
            rcnt_q     <= rcnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            irq_q      <= irq_d;
        end
    end

endmodule
